// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit ALU and its multi-byte sequencer:
// op field layout, named ops, flag bit positions and sequencer states.
package alu8_pkg;

    localparam int OP_K   = 3;
    localparam int OP_I   = 2;
    localparam int OP_J   = 1;
    localparam int OP_CIN = 0;

    localparam logic [3:0] OP_ADD = 4'b1100;
    localparam logic [3:0] OP_SUB = 4'b1111;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0010;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One bit of the second adder operand after B-modification:
    // i=1 selects B (j inverts it), i=0 selects the constant j.
    function automatic logic eff_b_bit(input logic i, input logic j, input logic b);
        return i ? (b ^ j) : j;
    endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit ALU: add-with-modified-B when k=1, AND/OR/XOR when k=0.
// The adder always runs, so o_c_out is meaningful only for arithmetic ops.
module alu8
    import alu8_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_op,
    output logic [7:0] o_y,
    output logic       o_c_out
);

    logic [7:0] w_bx;
    logic [8:0] w_sum;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bx
            assign w_bx[gi] = eff_b_bit(i_op[OP_I], i_op[OP_J], i_b[gi]);
        end
    endgenerate

    assign w_sum   = {1'b0, i_a} + {1'b0, w_bx} + {8'b0, i_op[OP_CIN]};
    assign o_c_out = w_sum[8];

    always_comb begin
        o_y = i_a & i_b;
        if (i_op[OP_K]) begin
            o_y = w_sum[7:0];
        end else if (i_op[OP_J]) begin
            o_y = i_a ^ i_b;
        end else if (i_op[OP_I]) begin
            o_y = i_a | i_b;
        end
    end

endmodule

// File: rtl/alu8_seq.sv
// Multi-precision sequencer: runs one NBYTES-wide op byte-serially (LSB first)
// through a single alu8, chaining carry between bytes and aggregating NZVC.
module alu8_seq
    import alu8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [8*NBYTES-1:0]   res,
    output logic [3:0]            flg
);

    localparam int              W        = 8 * NBYTES;
    localparam int              IW       = $clog2(NBYTES);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NBYTES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IW-1:0]      r_idx;
    logic               r_carry;
    logic               r_zacc;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2:0]         r_kij;
    logic [7:0]         r_res [NBYTES];
    logic [3:0]         r_flg;

    logic [7:0]         w_a_bytes [NBYTES];
    logic [7:0]         w_b_bytes [NBYTES];
    logic [7:0]         w_y;
    logic               w_c;
    logic               w_last;
    logic               w_bx_msb;
    logic [3:0]         w_flg_final;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign w_a_bytes[gi]      = r_a[8*gi +: 8];
            assign w_b_bytes[gi]      = r_b[8*gi +: 8];
            assign res[8*gi +: 8]     = r_res[gi];
        end
    endgenerate

    alu8 u_alu8 (
        .i_a     (w_a_bytes[r_idx]),
        .i_b     (w_b_bytes[r_idx]),
        .i_op    ({r_kij, r_carry}),
        .o_y     (w_y),
        .o_c_out (w_c)
    );

    assign w_last   = (r_idx == LAST_IDX);
    assign w_bx_msb = eff_b_bit(r_kij[OP_I-1], r_kij[OP_J-1], r_b[W-1]);

    // Flags only matter on the last byte; Z folds in all earlier result bytes.
    always_comb begin
        w_flg_final        = '0;
        w_flg_final[FLG_N] = w_y[7];
        w_flg_final[FLG_Z] = r_zacc & (w_y == 8'h00);
        if (r_kij[OP_K-1]) begin
            w_flg_final[FLG_C] = w_c;
            w_flg_final[FLG_V] = (r_a[W-1] & w_bx_msb & ~w_y[7]) |
                                 (~r_a[W-1] & ~w_bx_msb & w_y[7]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_kij   <= '0;
            r_flg   <= '0;
            for (int n = 0; n < NBYTES; n++) begin
                r_res[n] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_kij   <= op[3:1];
                        r_carry <= op[OP_CIN];
                        r_idx   <= '0;
                        r_zacc  <= 1'b1;
                    end
                end
                RUN: begin
                    r_res[r_idx] <= w_y;
                    r_carry      <= w_c;
                    r_zacc       <= r_zacc & (w_y == 8'h00);
                    r_idx        <= r_idx + 1'b1;
                    if (w_last) begin
                        r_flg <= w_flg_final;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == IDLE);
        done  = (r_state == DONE);
    end

    assign flg = r_flg;

endmodule

// File: tb/tb_alu8_seq.sv
// Bench for alu8_seq: full-width reference model checked every cycle, plus
// directed vectors with hand-computed results, busy-ignore and mid-run reset.
module tb_alu8_seq;
    import alu8_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [W-1:0]   res;
    logic [3:0]     flg;

    int n_checks = 0;
    int n_errors = 0;

    alu8_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .res   (res),
        .flg   (flg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full-width reference: returns {C,Z,V,N,result}
    function automatic logic [W+3:0] model_op(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                              input logic [3:0] mop);
        logic [W-1:0] bx;
        logic [W-1:0] r;
        logic [W:0]   s;
        logic         c;
        logic         v;
        if (mop[2]) bx = mop[1] ? ~mb : mb;
        else        bx = mop[1] ? {W{1'b1}} : {W{1'b0}};
        s = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mop[0]};
        if (mop[3]) begin
            r = s[W-1:0];
            c = s[W];
            v = (ma[W-1] & bx[W-1] & ~r[W-1]) | (~ma[W-1] & ~bx[W-1] & r[W-1]);
        end else begin
            if (mop[1])      r = ma ^ mb;
            else if (mop[2]) r = ma | mb;
            else             r = ma & mb;
            c = 1'b0;
            v = 1'b0;
        end
        return {c, (r == '0), v, r[W-1], r};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: accepted op completes NBYTES edges later
    bit           m_valid = 0;
    bit           m_busy;
    bit           m_done;
    int           m_cnt;
    logic [W-1:0] m_res;
    logic [3:0]   m_flg;
    logic [W-1:0] p_res;
    logic [3:0]   p_flg;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1;
            m_busy  <= 0;
            m_done  <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
            m_flg   <= '0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_res  <= p_res;
                m_flg  <= p_flg;
            end
            m_cnt <= m_cnt - 1;
        end else if (start) begin
            m_busy <= 1;
            m_cnt  <= NBYTES;
            {p_flg, p_res} <= model_op(a, b, op);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", W'(ready), W'(!m_busy && !m_done));
            chk("done", W'(done), W'(m_done));
            if (!m_busy) begin
                chk("res", res, m_res);
                chk("flg", W'(flg), W'(m_flg));
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] er, input logic [3:0] ef);
        int cyc;
        bit seen;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: op=%b no done within %0d cycles, expected %0d", o, cyc, NBYTES + 1);
        end else begin
            $display("op=%b a=%h b=%h res=%h flg=%b latency=%0d", o, va, vb, res, flg, cyc);
            chk("latency", W'(cyc), W'(NBYTES + 1));
            chk("lit_res", res, er);
            chk("lit_flg", W'(flg), W'(ef));
            chk("model_res", m_res, er);
            chk("model_flg", W'(m_flg), W'(ef));
        end
        @(negedge clk);
    endtask

    initial begin
        int n_done;
        logic [W-1:0] got_res;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_done", W'(done), W'(0));
        chk("rst_res", res, '0);
        chk("rst_flg", W'(flg), W'(0));
        rst_n = 1'b1;

        //      op      a             b             res           {C,Z,V,N}
        run_op(OP_ADD, 32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000);
        run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100);
        run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011);
        run_op(OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0001);
        run_op(OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1100);
        run_op(OP_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'b0000);
        run_op(OP_AND, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 4'b0100);
        run_op(OP_OR,  32'h80000000, 32'h00000001, 32'h80000001, 4'b0001);
        run_op(4'b1010, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b0001);
        run_op(4'b1001, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 4'b1100);
        run_op(OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1010);

        // Second start while busy must be dropped
        @(negedge clk);
        op = OP_ADD; a = 32'h10; b = 32'h20; start = 1'b1;
        @(negedge clk);
        a = 32'h1000; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        n_done  = 0;
        got_res = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                got_res = res;
            end
        end
        $display("busy-ignore: done pulses=%0d res=%h", n_done, got_res);
        chk("busy_done_count", W'(n_done), W'(1));
        chk("busy_res", got_res, 32'h30);

        // Reset two edges into a run abandons it
        @(negedge clk);
        op = OP_ADD; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-run reset: ready=%b res=%h flg=%b", ready, res, flg);
        chk("midrst_ready", W'(ready), W'(1));
        chk("midrst_res", res, '0);
        chk("midrst_flg", W'(flg), W'(0));
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", W'(n_done), W'(0));

        run_op(OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu8_seq.md
Name: alu8_seq

Overview:
Multi-precision sequencer around the 8-bit ALU (`alu8`).
- Accepts one NBYTES-wide operation through a start/ready handshake.
- Executes it byte-serially on a single `alu8` instance, least-significant byte first, with the carry chained through a register between bytes.
- Returns the full-width result and aggregate NZVC flags with a one-cycle done pulse.
- Sits between the instruction/control path and the 8-bit datapath, so wide arithmetic reuses the existing ALU.

Parameters:
- NBYTES, 4, number of bytes per operand; operand width W = 8*NBYTES; legal range 2..16

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only when ready=1
- op  in  4  ALU op {k,i,j,c_in}, same encoding as alu8
- a  in  W  operand A
- b  in  W  operand B
- ready  out  1  idle, able to accept start
- done  out  1  one-cycle pulse: result/flg valid
- res  out  W  full-width result
- flg  out  4  {C,Z,V,N}: bit3=C, bit2=Z, bit1=V, bit0=N

Behaviour:
Interface decisions:
- One clock, clk. Reset rst_n is synchronous and active-low.
- All state updates occur on the clk rising edge.

Reset (rst_n=0 at an edge):
- state=IDLE; ready=1, done=0, res=0, flg=0; byte index, carry and zero accumulators cleared.
- Reset mid-RUN abandons the operation; no done is produced.

States:
- IDLE:
  - ready=1.
  - start=1 at edge E0 latches a, b and op into internal registers; carry_reg<=op[0], idx<=0, z_acc<=1 -> RUN.
  - start=0 stays in IDLE.
- RUN:
  - ready=0.
  - Each cycle drives alu8 with a_byte=a_lat[8*idx+:8], b_byte=b_lat[8*idx+:8], op={op[3:1], carry_reg}.
  - At the edge: res[8*idx+:8] <= alu result byte; carry_reg <= alu c_out; z_acc <= z_acc & (result byte == 0); idx <= idx+1.
  - The edge processing idx=NBYTES-1 -> DONE.
- DONE:
  - ready=0, done=1 for exactly one cycle, then -> IDLE.
  - done is first high in the cycle after edge E0+NBYTES; latency from accepting edge to done = NBYTES+1 edges.
  - res/flg remain stable until the next accepted start, which clears nothing early: res bytes are overwritten as produced.

Input and op rules:
- start while ready=0 is ignored (not queued).
- a, b and op may change freely after acceptance.
- All 16 op codes are legal.
- Arithmetic when op[3]=1: i=1,j=0 -> A+B+cin; i=1,j=1 -> A+~B+cin (op=4'b1111 is A-B); i=0,j=1 -> A+all-ones+cin; i=0,j=0 -> A+cin.
- op[0] applies only to byte 0. Later bytes use the chained carry.
- Logic when op[3]=0: j=1 -> XOR; j=0,i=1 -> OR; j=0,i=0 -> AND.
- For logic ops the carry chain runs but does not affect res.

Final flags (registered at the last RUN edge, valid in DONE):
- N = res[W-1], for all ops.
- Z = 1 iff all W result bits are 0. Z is computed from res, not the adder sum, for all ops.
- C = final-byte c_out for arithmetic ops; 0 for logic ops. For subtract, C=1 means no borrow.
- V = (a_msb & bx_msb & ~r_msb) | (~a_msb & ~bx_msb & r_msb) for arithmetic ops; 0 for logic ops.
  - bx_msb is the MSB of the effective second adder operand after B-modification (~B for subtract).
  - V is computed in this block; the alu8 V flag is not used.

Decomposition:
- Package alu8_pkg:
  - op field bit indices (K=3, I=2, J=1, CIN=0);
  - named op constants: OP_ADD=4'b1100, OP_SUB=4'b1111, OP_AND=4'b0000, OP_OR=4'b0100, OP_XOR=4'b0010;
  - flag bit indices (FLG_C=3, FLG_Z=2, FLG_V=1, FLG_N=0);
  - state encoding typedef {IDLE, RUN, DONE}.
- One sub-module: an instance of the existing alu8, unmodified.
- Byte select/merge, carry register, flag logic and FSM live in alu8_seq.

Test Plan (NBYTES=4):
- OP_ADD a=0x000000FF b=0x00000001, start at E0 -> done high in cycle after E0+4; res=0x00000100, flg C=0 Z=0 V=0 N=0; ready=0 from E0 until done; done high exactly 1 cycle.
- OP_ADD a=0xFFFFFFFF b=0x00000001 -> res=0x00000000, C=1 Z=1 V=0 N=0.
- OP_ADD a=0x7FFFFFFF b=0x00000001 -> res=0x80000000, V=1 N=1 C=0 Z=0.
- OP_SUB a=0x00000000 b=0x00000001 -> res=0xFFFFFFFF, C=0 N=1 V=0 Z=0.
- OP_SUB a=5 b=5 -> res=0, C=1 Z=1.
- OP_XOR a=0xF0F0F0F0 b=0xFFFF0000 -> res=0x0F0FF0F0, C=0 V=0 N=0 Z=0.
- OP_AND a=0x0F0F0F0F b=0xF0F0F0F0 -> res=0, Z=1.
- Start ignored while busy, then reset mid-run:
  - Start OP_ADD, assert start again at E0+1 with other operands -> second request ignored, single done with first result.
  - Then start again and drive rst_n=0 at E0+2 -> no done; next cycle ready=1, res=0, flg=0.
  - A new OP_ADD 1+2 afterwards gives res=3.
